// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard detection for a five-stage pipeline: operand forward
// selects, load-use stall, control-hazard flush, and saturating event counters.
module fwd_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             CntClr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [1:0]       FWD_RF  = 2'b00;
  localparam logic [1:0]       FWD_WB  = 2'b01;
  localparam logic [1:0]       FWD_MEM = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       lw_stall;

  // Destination tracking follows the instruction stream and never stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RdM       <= '0;
      RdW       <= '0;
      RegWriteM <= 1'b0;
      RegWriteW <= 1'b0;
    end else begin
      RdM       <= RdE;
      RegWriteM <= RegWriteE;
      RdW       <= RdM;
      RegWriteW <= RegWriteM;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = FWD_MEM;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  always_comb begin
    lw_stall = ResultSrcE0 & RegWriteE & (RdE != 5'd0) &
               ((RdE == Rs1D) | (RdE == Rs2D));
  end

  // Controls are held low while reset is asserted, independent of the inputs.
  always_comb begin
    StallF = lw_stall & ~reset;
    StallD = lw_stall & ~reset;
    FlushD = PCSrcE & ~reset;
    FlushE = (lw_stall | PCSrcE) & ~reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
    end else if (CntClr) begin
      StallCount <= '0;
    end else if (lw_stall && (StallCount != CNT_MAX)) begin
      StallCount <= StallCount + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      FlushCount <= '0;
    end else if (CntClr) begin
      FlushCount <= '0;
    end else if (PCSrcE && (FlushCount != CNT_MAX)) begin
      FlushCount <= FlushCount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus random
// stimulus compared every cycle against a history-based reference model.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0;
  logic       RegWriteE = 1'b0, ResultSrcE0 = 1'b0, PCSrcE = 1'b0, CntClr = 1'b0;

  logic [1:0]  fa, fb, fa4, fb4;
  logic        sf, sd, fd, fe, sf4, sd4, fd4, fe4;
  logic [15:0] sc, fc;
  logic [3:0]  sc4, fc4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .CntClr(CntClr), .ForwardAE(fa), .ForwardBE(fb), .StallF(sf), .StallD(sd),
    .FlushD(fd), .FlushE(fe), .StallCount(sc), .FlushCount(fc)
  );

  fwd_hazard_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .CntClr(CntClr), .ForwardAE(fa4), .ForwardBE(fb4), .StallF(sf4), .StallD(sd4),
    .FlushD(fd4), .FlushE(fe4), .StallCount(sc4), .FlushCount(fc4)
  );

  // Reference model: hist_rd[k]/hist_we[k] = Execute writer seen k edges ago.
  int hist_rd [1:2] = '{0, 0};
  int hist_we [1:2] = '{0, 0};
  int m_sc = 0, m_fc = 0, m_sc4 = 0, m_fc4 = 0;

  function automatic int exp_lw();
    return (ResultSrcE0 && RegWriteE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)) ? 1 : 0;
  endfunction

  function automatic int exp_fwd(input int rs);
    for (int age = 1; age <= 2; age++)
      if (hist_we[age] != 0 && hist_rd[age] != 0 && hist_rd[age] == rs)
        return (age == 1) ? 2 : 1;
    return 0;
  endfunction

  function automatic int bump(input int cnt, input int hit, input int maxv);
    if (CntClr) return 0;
    if (hit != 0) return (cnt + 1 > maxv) ? maxv : cnt + 1;
    return cnt;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_rd <= '{0, 0};
      hist_we <= '{0, 0};
      m_sc <= 0; m_fc <= 0; m_sc4 <= 0; m_fc4 <= 0;
    end else begin
      hist_rd[2] <= hist_rd[1];
      hist_we[2] <= hist_we[1];
      hist_rd[1] <= int'(RdE);
      hist_we[1] <= int'(RegWriteE);
      m_sc  <= bump(m_sc,  exp_lw(), 65535);
      m_fc  <= bump(m_fc,  int'(PCSrcE), 65535);
      m_sc4 <= bump(m_sc4, exp_lw(), 15);
      m_fc4 <= bump(m_fc4, int'(PCSrcE), 15);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int lw, pc;
    lw = reset ? 0 : exp_lw();
    pc = reset ? 0 : int'(PCSrcE);
    chk("ForwardAE", int'(fa), exp_fwd(int'(Rs1E)));
    chk("ForwardBE", int'(fb), exp_fwd(int'(Rs2E)));
    chk("ForwardAE4", int'(fa4), exp_fwd(int'(Rs1E)));
    chk("StallF", int'(sf), lw);
    chk("StallD", int'(sd), lw);
    chk("FlushD", int'(fd), pc);
    chk("FlushE", int'(fe), (lw != 0 || pc != 0) ? 1 : 0);
    chk("StallCount", int'(sc), m_sc);
    chk("FlushCount", int'(fc), m_fc);
    chk("StallCount4", int'(sc4), m_sc4);
    chk("FlushCount4", int'(fc4), m_fc4);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
    RegWriteE = 0; ResultSrcE0 = 0; PCSrcE = 0; CntClr = 0;
  endtask

  initial begin
    int c0;
    idle();
    step(); step();
    chk("rst_fwdA", int'(fa), 0);
    chk("rst_cnt", int'(sc), 0);
    #1 reset = 1'b0;
    step();

    // Memory then Writeback forward of x5, then register file.
    RdE = 5; RegWriteE = 1; step();
    RdE = 0; RegWriteE = 0; Rs1E = 5; #3;
    chk("d028_mem", int'(fa), 2);
    step(); #3;
    chk("d028_wb", int'(fa), 1);
    step(); #3;
    chk("d028_rf", int'(fa), 0);

    // Back-to-back writers to x7: Memory has priority.
    idle(); RdE = 7; RegWriteE = 1; step(); step();
    RegWriteE = 0; RdE = 0; Rs2E = 7; #3;
    chk("d029_prio", int'(fb), 2);

    // Load-use stall, then the same with RdE = x0.
    idle(); step();
    ResultSrcE0 = 1; RegWriteE = 1; RdE = 3; Rs2D = 3; #2;
    c0 = int'(sc);
    chk("d030_stallF", int'(sf), 1);
    chk("d030_flushE", int'(fe), 1);
    chk("d030_flushD", int'(fd), 0);
    step();
    chk("d030_cnt", int'(sc), c0 + 1);
    RdE = 0; Rs2D = 0; #2;
    chk("d030_x0", int'({sf, sd, fd, fe}), 0);

    // Load-use together with taken branch.
    RdE = 3; Rs2D = 3; PCSrcE = 1; #2;
    c0 = int'(fc);
    chk("d031_all", int'({sf, sd, fd, fe}), 15);
    step();
    chk("d031_fcnt", int'(fc), c0 + 1);

    // Four-bit flush counter saturates, then clear wins over increment.
    idle(); CntClr = 1; step();
    CntClr = 0; PCSrcE = 1;
    for (int i = 0; i < 20; i++) step();
    chk("d032_sat", int'(fc4), 15);
    CntClr = 1; step();
    chk("d032_clr", int'(fc4), 0);

    // Asynchronous reset between edges with tracking loaded.
    idle(); RdE = 9; RegWriteE = 1; step(); step();
    Rs1E = 9; Rs2E = 9; ResultSrcE0 = 1; Rs1D = 9; PCSrcE = 1; #1;
    chk("d033_pre", int'(fa), 2);
    reset = 1'b1; #1;
    chk("d033_fwd", int'({fa, fb}), 0);
    chk("d033_ctl", int'({sf, sd, fd, fe}), 0);
    chk("d033_cnt", int'(fc) + int'(sc), 0);
    @(negedge clk); #1 reset = 1'b0;
    step(); #1;
    chk("d033_post", int'(fa), 2);

    // Random traffic on a small register range to get frequent hits.
    idle(); step();
    for (int i = 0; i < 3000; i++) begin
      Rs1D = 5'($urandom_range(0, 7));
      Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7));
      Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7));
      RegWriteE   = ($urandom_range(0, 3) != 0);
      ResultSrcE0 = ($urandom_range(0, 2) == 0);
      PCSrcE      = ($urandom_range(0, 3) == 0);
      CntClr      = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b1;
        #1 chk("rnd_async", int'({fa, fb, sf, fe}) + int'(sc) + int'(fc), 0);
        @(negedge clk); #1 reset = 1'b0;
      end
      step();
    end

    idle(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, the width of each event counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have ports Rs1D, Rs2D, input, 5 each: source register numbers of the instruction in Decode.
REQ-005 The block SHALL have ports Rs1E, Rs2E, RdE, input, 5 each: source and destination register numbers of the instruction in Execute.
REQ-006 The block SHALL have port RegWriteE, input, 1: the Execute instruction writes RdE.
REQ-007 The block SHALL have port ResultSrcE0, input, 1: the Execute instruction is a load.
REQ-008 The block SHALL have port PCSrcE, input, 1: a branch or jump is taken in Execute.
REQ-009 The block SHALL have port CntClr, input, 1: synchronous clear of both counters.
REQ-010 The block SHALL have ports ForwardAE, ForwardBE, output, 2 each: selects for the operand-A and operand-B 3:1 forwarding muxes.
REQ-011 The block SHALL have ports StallF, StallD, FlushD, FlushE, output, 1 each: pipeline control.
REQ-012 The block SHALL have ports StallCount, FlushCount, output, CNT_W each: event counters.

Function
REQ-013 Tracking registers (RdM, RegWriteM, RdW, RegWriteW) SHALL advance every cycle: RdM<=RdE, RegWriteM<=RegWriteE, RdW<=RdM, RegWriteW<=RegWriteM; the block never stalls its own tracking.
REQ-014 Forward encoding SHALL be: 2'b10 = Memory-stage ALU result, 2'b01 = Writeback result, 2'b00 = register file; 2'b11 SHALL never be driven.
REQ-015 ForwardAE SHALL be 2'b10 when RegWriteM, RdM!=0 and RdM==Rs1E; else 2'b01 when RegWriteW, RdW!=0 and RdW==Rs1E; else 2'b00; ForwardBE is the same with Rs2E.
REQ-016 When Memory and Writeback both match, Memory (2'b10) SHALL win.
REQ-017 Register x0 (Rs or Rd == 0) SHALL never produce a forward or a stall.
REQ-018 lwStall SHALL be ResultSrcE0 & RegWriteE & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D)).
REQ-019 StallF = StallD = lwStall; FlushD = PCSrcE; FlushE = lwStall | PCSrcE; all are combinational, with zero-cycle latency.
REQ-020 When lwStall and PCSrcE are both 1, all four controls SHALL be 1 (the flush discards the stalled Decode instruction).
REQ-021 StallCount SHALL increment by 1 on each clock edge where lwStall=1, and FlushCount on each edge where PCSrcE=1.
REQ-022 Counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-023 CntClr=1 SHALL load 0 into both counters on the next edge, overriding a simultaneous increment.
REQ-024 Forward selects SHALL depend only on current inputs and tracking registers; there is no multi-cycle latency beyond the tracking pipeline.

Reset
REQ-025 While reset=1, RdM, RdW, RegWriteM, RegWriteW, StallCount and FlushCount SHALL be 0, giving ForwardAE = ForwardBE = 2'b00.
REQ-026 While reset=1, StallF, StallD, FlushD and FlushE SHALL be forced to 0 regardless of inputs.
REQ-027 Reset asserted mid-operation SHALL clear state immediately, without waiting for a clock edge; the first post-reset edge tracks the then-current RdE/RegWriteE.

Verification
REQ-028 Drive RdE=5, RegWriteE=1 for one cycle, then Rs1E=5 -> ForwardAE=10; on the next cycle with Rs1E=5 and no new writer -> ForwardAE=01; one cycle later -> 00.
REQ-029 Back-to-back writers to x7 in consecutive cycles, then Rs2E=7 -> ForwardBE=10 (Memory priority).
REQ-030 Drive ResultSrcE0=1, RegWriteE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1, FlushD=0, and StallCount+1 at the edge; the same stimulus with RdE=0 -> all 0.
REQ-031 Drive PCSrcE=1 together with the load-use condition -> all four controls 1; both counters increment.
REQ-032 Set CNT_W=4, hold PCSrcE=1 for 20 cycles -> FlushCount stops at 15; assert CntClr together with PCSrcE -> 0.
REQ-033 Assert reset asynchronously between edges with tracking regs loaded -> forwards 00, controls 0 and counters 0 immediately.
